pp_timer_bank: RTL and testbench
================================

// Module: pp_timer_bank
// PURPOSE
//  Parametrised multi-channel timer peripheral on the core peripheral bus (addr/wr/rd/data_in/data_out).
//  - NUM_CH independent compare channels share one programmable prescaler.
//  - Each channel runs one-shot or periodic (auto-reload), with per-channel pending and enable bits.
//  - Drives one combined interrupt line to the core; replaces the single free-running mtime/mtimecmp timer.
// PARAMETERS
//  NUM_CH   4   number of channels, 1..8
//  CNT_W    32  channel counter/compare width, 8..32
//  PRESC_W  16  prescaler reload width, 1..32
// PORTS
//  clk       in   1       single clock; all logic on posedge clk
//  rst       in   1       synchronous, active-high reset
//  addr      in   8       register byte offset within block
//  wr        in   1       write strobe, one cycle per access
//  rd        in   1       read strobe, one cycle per access
//  data_in   in   32      write data
//  data_out  out  32      read data, registered
//  timer     out  1       interrupt, level, registered
//  ch_irq    out  NUM_CH  per-channel masked pending (pend & ie), registered
// BEHAVIOUR
//  Map: 0x00 PRESC[PRESC_W-1:0] RW | 0x04 PEND[NUM_CH-1:0] R/W1C | 0x08 IE[NUM_CH-1:0] RW
//  Channel i at base B = 0x10*(i+1):
//   B+0 CTRL {ie_mirror? no: bit0 EN, bit1 MODE (0 one-shot, 1 periodic)} RW
//   B+4 CMP RW | B+8 CNT RW
//  Unmapped offsets: writes ignored, reads return 0. Fields zero-extended to 32 bits on read.
//  Reset (rst=1 at a clk edge):
//   - PRESC=0, PEND=0, IE=0; all EN/MODE/CNT = 0; all CMP = all-ones.
//   - Prescaler counter = 0; data_out=0; timer=0; ch_irq=0.
//   - Reset mid-count aborts everything; no pending bit survives.
//  Prescaler:
//   - pcnt counts 0..PRESC; tick=1 in the cycle pcnt==PRESC, after which pcnt wraps to 0.
//   - PRESC=0 -> tick every cycle.
//   - A PRESC write also clears pcnt; the next tick comes PRESC+1 cycles later.
//  Channel, on a tick with EN=1:
//   - CNT!=CMP -> CNT+1, wrapping mod 2^CNT_W.
//   - CNT==CMP -> set PEND[i]; then periodic: CNT<=0, EN kept; one-shot: CNT held, EN<=0.
//   - Periodic period = (CMP+1)*(PRESC+1) clk cycles.
//  EN=0: CNT frozen, no match evaluation.
//  CTRL write with EN 0->1 clears CNT to 0 in the same edge.
//  Priority on a channel in the same cycle: bus write to CNT/CTRL > tick update.
//   - CMP write takes effect for the next tick's comparison.
//  PEND:
//   - W1C: writing 1 clears the bit, writing 0 has no effect.
//   - A match in the same cycle as W1C leaves the bit set (set wins).
//   - Reads have no side effects.
//  Interrupts: ch_irq <= PEND & IE; timer <= |(PEND & IE). Both lag PEND by 1 cycle.
//   - Clearing IE drops timer 1 cycle later; PEND keeps its value.
//  Read latency 1: on rd, data_out <= reg[addr] at that edge and holds until the next rd.
//   - Simultaneous rd and wr to the same register returns the pre-write value.
// STRUCTURE
//  Shared header pvt_timer_defs.v: PRESC/PEND/IE offsets, channel stride 0x10, CTRL/CMP/CNT sub-offsets, CTRL bit positions.
//  Sub-module pp_timer_ch (one channel): ports
//   - clk, rst, tick, wr_ctrl, wr_cmp, wr_cnt, wdata
//   - outputs: en, mode, cmp, cnt, match (1-cycle pulse)
//  Instantiated NUM_CH times by generate.
//  Top holds the prescaler, PEND/IE, address decode, read mux and interrupt registers.
// TESTING
//  1. Reset, then read every register -> PRESC/PEND/IE/CTRL/CNT = 0, CMP = all-ones, timer=0.
//  2. PRESC=3, IE=1, ch0 CMP=4 MODE=1 EN=1 -> PEND[0] every 20 cycles, CNT sequence 0..4,0..;
//     timer high 1 cycle after PEND.
//  3. ch1 one-shot CMP=2, PRESC=0 -> PEND[1] set 3 cycles after enable, EN reads 0, CNT holds 2, no second event.
//  4. Write PEND=1 in the same cycle as the ch0 match -> PEND[0] stays 1; a W1C later clears it and timer drops 1 cycle after.
//  5. ch2: CNT write in a tick cycle -> written value wins. EN 0->1 restarts CNT at 0.
//     rst asserted mid-count -> all state back to reset values.
//  6. NUM_CH=8, CNT_W=8: ch7 at 0x80 responds. CMP=0xFF, CNT=0xFE periodic -> match at 0xFF then wraps to 0.
//     Offset 0x0C reads 0.

Source files
------------

// File: rtl/pp_timer_bank_pkg.sv
// Shared definitions for the pp_timer_bank peripheral.
//  - Register byte offsets for the global block (PRESC, PEND, IE).
//  - Channel stride and per-channel sub-offsets (CTRL, CMP, CNT).
//  - CTRL bit positions and the channel mode encoding.
//  - ch_base(): byte address of channel idx's register window.
package pp_timer_bank_pkg;

  localparam logic [7:0] PRESC_OFS   = 8'h00;
  localparam logic [7:0] PEND_OFS    = 8'h04;
  localparam logic [7:0] IE_OFS      = 8'h08;

  localparam logic [7:0] CH_STRIDE   = 8'h10;
  localparam logic [7:0] CH_CTRL_OFS = 8'h00;
  localparam logic [7:0] CH_CMP_OFS  = 8'h04;
  localparam logic [7:0] CH_CNT_OFS  = 8'h08;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_BIT = 1;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } ch_mode_e;

  // Channel 0 sits one stride above the global registers, so the
  // window of channel idx starts at CH_STRIDE * (idx + 1).
  function automatic logic [7:0] ch_base(input int idx);
    return CH_STRIDE * 8'(idx + 1);
  endfunction

endpackage

// File: rtl/pp_timer_bank_ch.sv
// One compare channel of pp_timer_bank.
// Ports:
//  clk, rst          clock, synchronous active-high reset
//  tick              shared prescaler tick
//  wr_ctrl/cmp/cnt   decoded bus write strobes for this channel
//  wdata             bus write data
//  en, mode          CTRL fields
//  cmp, cnt          compare value and running counter
//  match             combinational pulse in the cycle a match is taken;
//                    the top turns it into the PEND bit at the same edge
module pp_timer_ch
  import pp_timer_bank_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wr_ctrl,
  input  logic             wr_cmp,
  input  logic             wr_cnt,
  input  logic [31:0]      wdata,
  output logic             en,
  output logic             mode,
  output logic [CNT_W-1:0] cmp,
  output logic [CNT_W-1:0] cnt,
  output logic             match
);

  logic wr_state;
  logic unused_wdata;

  // A write to CTRL or CNT owns the channel for that cycle: the tick is
  // dropped entirely, including the match it would have produced.
  assign wr_state     = wr_ctrl | wr_cnt;
  assign match        = tick & en & (cnt == cmp) & ~wr_state;
  assign unused_wdata = ^wdata;

  // Channel state. CMP writes are independent of the tick, so a new
  // compare value is only seen by the following tick's comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      en   <= 1'b0;
      mode <= 1'b0;
      cmp  <= '1;
      cnt  <= '0;
    end else begin
      if (wr_cmp) begin
        cmp <= wdata[CNT_W-1:0];
      end
      if (wr_state) begin
        if (wr_ctrl) begin
          en   <= wdata[CTRL_EN_BIT];
          mode <= wdata[CTRL_MODE_BIT];
          // Enabling a stopped channel restarts it from zero.
          if (wdata[CTRL_EN_BIT] && !en) begin
            cnt <= '0;
          end
        end
        if (wr_cnt) begin
          cnt <= wdata[CNT_W-1:0];
        end
      end else if (tick && en) begin
        if (cnt == cmp) begin
          if (ch_mode_e'(mode) == MODE_PERIODIC) begin
            cnt <= '0;
          end else begin
            en <= 1'b0;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pp_timer_bank.sv
// Multi-channel timer peripheral: NUM_CH compare channels sharing one
// programmable prescaler, with W1C pending bits, per-channel interrupt
// enables and one combined interrupt line.
// Ports:
//  clk, rst   clock, synchronous active-high reset
//  addr       register byte offset
//  wr, rd     single-cycle write/read strobes
//  data_in    write data
//  data_out   registered read data (one cycle latency, held between reads)
//  timer      registered OR of (PEND & IE)
//  ch_irq     registered PEND & IE per channel
module pp_timer_bank
  import pp_timer_bank_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        addr,
  input  logic              wr,
  input  logic              rd,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              timer,
  output logic [NUM_CH-1:0] ch_irq
);

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;
  logic               tick;
  logic [NUM_CH-1:0]  pend;
  logic [NUM_CH-1:0]  ie;
  logic [NUM_CH-1:0]  pend_clr;
  logic               wr_presc;
  logic               wr_pend;
  logic               wr_ie;
  logic [NUM_CH-1:0]  wr_ctrl;
  logic [NUM_CH-1:0]  wr_cmp;
  logic [NUM_CH-1:0]  wr_cnt;
  logic [NUM_CH-1:0]  ch_en;
  logic [NUM_CH-1:0]  ch_mode;
  logic [NUM_CH-1:0]  ch_match;
  logic [CNT_W-1:0]   ch_cmp [NUM_CH];
  logic [CNT_W-1:0]   ch_cnt [NUM_CH];
  logic [31:0]        rdata;

  assign wr_presc = wr && (addr == PRESC_OFS);
  assign wr_pend  = wr && (addr == PEND_OFS);
  assign wr_ie    = wr && (addr == IE_OFS);
  assign pend_clr = wr_pend ? data_in[NUM_CH-1:0] : '0;
  assign tick     = (pcnt == presc);

  // Prescaler: counts 0..PRESC and ticks on the terminal count. A PRESC
  // write restarts the count so the first tick lands PRESC+1 cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (wr_presc || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Global registers. In PEND the clear is applied before the set so a
  // match arriving together with a W1C keeps the bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      ie    <= '0;
      pend  <= '0;
    end else begin
      if (wr_presc) begin
        presc <= data_in[PRESC_W-1:0];
      end
      if (wr_ie) begin
        ie <= data_in[NUM_CH-1:0];
      end
      pend <= (pend & ~pend_clr) | ch_match;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [7:0] BASE = ch_base(g);

    assign wr_ctrl[g] = wr && (addr == BASE + CH_CTRL_OFS);
    assign wr_cmp[g]  = wr && (addr == BASE + CH_CMP_OFS);
    assign wr_cnt[g]  = wr && (addr == BASE + CH_CNT_OFS);

    pp_timer_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .wr_ctrl (wr_ctrl[g]),
      .wr_cmp  (wr_cmp[g]),
      .wr_cnt  (wr_cnt[g]),
      .wdata   (data_in),
      .en      (ch_en[g]),
      .mode    (ch_mode[g]),
      .cmp     (ch_cmp[g]),
      .cnt     (ch_cnt[g]),
      .match   (ch_match[g])
    );
  end

  // Read mux over the current (pre-write) register values; anything not
  // decoded reads as zero.
  always_comb begin
    rdata = '0;
    if (addr == PRESC_OFS) begin
      rdata = 32'(presc);
    end else if (addr == PEND_OFS) begin
      rdata = 32'(pend);
    end else if (addr == IE_OFS) begin
      rdata = 32'(ie);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == ch_base(i) + CH_CTRL_OFS) begin
        rdata = {30'b0, ch_mode[i], ch_en[i]};
      end else if (addr == ch_base(i) + CH_CMP_OFS) begin
        rdata = 32'(ch_cmp[i]);
      end else if (addr == ch_base(i) + CH_CNT_OFS) begin
        rdata = 32'(ch_cnt[i]);
      end
    end
  end

  // Output registers: read data is captured only on rd and then held;
  // interrupts follow PEND & IE one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      ch_irq   <= '0;
      timer    <= 1'b0;
    end else begin
      if (rd) begin
        data_out <= rdata;
      end
      ch_irq <= pend & ie;
      timer  <= |(pend & ie);
    end
  end

endmodule

// File: tb/tb_pp_timer_bank.sv
// Self-checking bench for pp_timer_bank. A 4-channel/32-bit instance is the
// main target; an 8-channel/8-bit instance on the same bus covers the wide
// map and narrow counter wrap. All tasks start and end at a falling edge.
module tb_pp_timer_bank;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 32;
  localparam int PRESC_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic        wr;
  logic        rd;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        timer;
  logic [NUM_CH-1:0] ch_irq;
  logic [31:0] data_out8;
  logic        timer8;
  logic [7:0]  ch_irq8;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_edge = 0;

  // Behavioural reference state for the 4-channel instance.
  int unsigned m_presc;
  int unsigned m_pcnt;
  logic [NUM_CH-1:0] m_pend;
  logic [NUM_CH-1:0] m_ie;
  bit          m_en   [NUM_CH];
  bit          m_mode [NUM_CH];
  logic [31:0] m_cmp  [NUM_CH];
  logic [31:0] m_cnt  [NUM_CH];
  logic [31:0] m_dout;
  logic        m_timer;
  logic [NUM_CH-1:0] m_irq;

  pp_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(data_out), .timer(timer), .ch_irq(ch_irq)
  );

  pp_timer_bank #(.NUM_CH(8), .CNT_W(8), .PRESC_W(PRESC_W)) dut8 (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .data_in(data_in),
    .data_out(data_out8), .timer(timer8), .ch_irq(ch_irq8)
  );

  always #5 clk = ~clk;

  // Edge counter: at the falling edge after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    wr = 1'b0; rd = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    addr = a; data_in = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    last_edge = cyc;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d4,
                          output logic [31:0] d8);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    d4 = data_out;
    d8 = data_out8;
  endtask

  // Number of prescaler ticks landing on edges in (lo, hi] when PRESC=p
  // was written at edge ep.
  function automatic int ticks_between(int ep, int p, int lo, int hi);
    int n = 0;
    for (int t = lo + 1; t <= hi; t++)
      if (t > ep && ((t - ep) % (p + 1)) == 0) n++;
    return n;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int ch;
    if (a == 8'h00) return m_presc;
    if (a == 8'h04) return 32'(m_pend);
    if (a == 8'h08) return 32'(m_ie);
    if (int'(a) >= 16 && int'(a) < 16 * (NUM_CH + 1)) begin
      ch = int'(a) / 16 - 1;
      case (int'(a) % 16)
        0: return {30'b0, m_mode[ch], m_en[ch]};
        4: return m_cmp[ch];
        8: return m_cnt[ch];
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_presc = 0; m_pcnt = 0; m_pend = '0; m_ie = '0;
    m_dout = '0; m_timer = 1'b0; m_irq = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_en[i] = 1'b0; m_mode[i] = 1'b0; m_cmp[i] = '1; m_cnt[i] = '0;
    end
  endtask

  // Advance the model over one rising edge with the given bus inputs.
  task automatic model_step(input bit w, input bit r, input logic [7:0] a,
                            input logic [31:0] d);
    logic [31:0] rv;
    logic [NUM_CH-1:0] irq, np;
    bit tk, chw;
    int kind;
    rv = model_read(a);
    tk = (m_pcnt == m_presc);
    irq = m_pend & m_ie;
    np = m_pend;
    if (w && a == 8'h04) np = np & ~d[NUM_CH-1:0];
    for (int ch = 0; ch < NUM_CH; ch++) begin
      chw = w && (int'(a) / 16 - 1 == ch) && int'(a) >= 16;
      kind = int'(a) % 16;
      if (chw && kind == 0) begin
        if (d[0] && !m_en[ch]) m_cnt[ch] = '0;
        m_en[ch] = d[0];
        m_mode[ch] = d[1];
      end else if (chw && kind == 8) begin
        m_cnt[ch] = d;
      end else if (tk && m_en[ch]) begin
        if (m_cnt[ch] == m_cmp[ch]) begin
          np[ch] = 1'b1;
          if (m_mode[ch]) m_cnt[ch] = '0;
          else m_en[ch] = 1'b0;
        end else begin
          m_cnt[ch] = m_cnt[ch] + 1;
        end
      end
      if (chw && kind == 4) m_cmp[ch] = d;
    end
    if (w && a == 8'h00) begin
      m_presc = int'(d[PRESC_W-1:0]);
      m_pcnt = 0;
    end else begin
      m_pcnt = tk ? 0 : m_pcnt + 1;
    end
    if (w && a == 8'h08) m_ie = d[NUM_CH-1:0];
    m_pend = np;
    if (r) m_dout = rv;
    m_irq = irq;
    m_timer = |irq;
  endtask

  task automatic test_reset();
    logic [31:0] d4, d8, exp;
    logic [7:0] a;
    do_reset();
    n_cmp++;
    if (data_out !== 32'h0 || timer !== 1'b0 || ch_irq !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs got dout=%h timer=%b irq=%b exp 0/0/0",
               data_out, timer, ch_irq);
    end
    for (int k = 0; k < 3 + 3 * NUM_CH + 2; k++) begin
      if (k < 3) begin
        a = 8'(4 * k); exp = 32'h0;
      end else if (k < 3 + 3 * NUM_CH) begin
        a = 8'(16 * ((k - 3) / 3 + 1) + 4 * ((k - 3) % 3));
        exp = ((k - 3) % 3 == 1) ? 32'hFFFF_FFFF : 32'h0;
      end else begin
        a = (k == 3 + 3 * NUM_CH) ? 8'h0C : 8'h50;
        exp = 32'h0;
      end
      bus_read(a, d4, d8);
      n_cmp++;
      if (d4 !== exp) begin
        n_err++;
        $display("[TB] FAIL reset_read addr=%h got=%h exp=%h", a, d4, exp);
      end
    end
  endtask

  task automatic test_periodic();
    int ep, e0, n;
    logic [31:0] exp_cnt;
    logic [31:0] d4, d8;
    do_reset();
    bus_write(8'h00, 32'd3); ep = last_edge;
    bus_write(8'h08, 32'd1);
    bus_write(8'h14, 32'd4);
    bus_write(8'h10, 32'd3); e0 = last_edge;
    addr = 8'h18; rd = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      n = ticks_between(ep, 3, e0, cyc - 1);
      exp_cnt = 32'(n % 5);
      n_cmp++;
      if (data_out !== exp_cnt) begin
        n_err++;
        $display("[TB] FAIL periodic_cnt edge=%0d got=%h exp=%h", cyc, data_out, exp_cnt);
      end
      n_cmp++;
      if (timer !== (n >= 5)) begin
        n_err++;
        $display("[TB] FAIL periodic_timer edge=%0d got=%b exp=%b", cyc, timer, n >= 5);
      end
    end
    rd = 1'b0;
    bus_read(8'h04, d4, d8);
    n_cmp++;
    if (d4 !== 32'h1 || ch_irq !== 4'h1) begin
      n_err++;
      $display("[TB] FAIL periodic_pend got pend=%h irq=%h exp 1/1", d4, ch_irq);
    end
  endtask

  task automatic test_oneshot();
    int e0;
    logic [31:0] exp, d4, d8;
    do_reset();
    bus_write(8'h00, 32'd0);
    bus_write(8'h24, 32'd2);
    bus_write(8'h20, 32'd1); e0 = last_edge;
    addr = 8'h04; rd = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp = ((cyc - 1) >= e0 + 3) ? 32'h2 : 32'h0;
      n_cmp++;
      if (data_out !== exp) begin
        n_err++;
        $display("[TB] FAIL oneshot_pend edge=%0d got=%h exp=%h", cyc, data_out, exp);
      end
    end
    rd = 1'b0;
    bus_read(8'h20, d4, d8);
    n_cmp++;
    if (d4 !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL oneshot_ctrl got=%h exp=0", d4);
    end
    bus_read(8'h28, d4, d8);
    n_cmp++;
    if (d4 !== 32'h2) begin
      n_err++;
      $display("[TB] FAIL oneshot_cnt got=%h exp=2", d4);
    end
    bus_write(8'h04, 32'h2);
    repeat (10) @(negedge clk);
    bus_read(8'h04, d4, d8);
    n_cmp++;
    if (d4 !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL oneshot_second_event got=%h exp=0", d4);
    end
  endtask

  task automatic test_w1c_collision();
    int e0;
    logic [31:0] d4, d8;
    do_reset();
    bus_write(8'h00, 32'd0);
    bus_write(8'h08, 32'd1);
    bus_write(8'h14, 32'd3);
    bus_write(8'h10, 32'd3); e0 = last_edge;
    while (cyc < e0 + 7) @(negedge clk);
    bus_write(8'h04, 32'h1);
    bus_write(8'h10, 32'h0);
    bus_read(8'h04, d4, d8);
    n_cmp++;
    if (d4 !== 32'h1) begin
      n_err++;
      $display("[TB] FAIL w1c_set_wins got=%h exp=1", d4);
    end
    bus_write(8'h04, 32'h1);
    n_cmp++;
    if (timer !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL w1c_timer_lag got=%b exp=1", timer);
    end
    @(negedge clk);
    n_cmp++;
    if (timer !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL w1c_timer_drop got=%b exp=0", timer);
    end
  endtask

  task automatic test_priority();
    logic [31:0] d4, d8;
    logic [31:0] exp_rd [7];
    logic [7:0]  a_rd   [7];
    do_reset();
    bus_write(8'h00, 32'd0);
    bus_write(8'h34, 32'd100);
    bus_write(8'h30, 32'd1);
    repeat (5) @(negedge clk);
    bus_write(8'h38, 32'd50);
    bus_read(8'h38, d4, d8);
    n_cmp++;
    if (d4 !== 32'd50) begin
      n_err++;
      $display("[TB] FAIL prio_cnt_write got=%0d exp=50", d4);
    end
    bus_read(8'h38, d4, d8);
    n_cmp++;
    if (d4 !== 32'd51) begin
      n_err++;
      $display("[TB] FAIL prio_resume got=%0d exp=51", d4);
    end
    bus_write(8'h30, 32'd0);
    repeat (3) @(negedge clk);
    bus_read(8'h38, d4, d8);
    n_cmp++;
    if (d4 !== 32'd52) begin
      n_err++;
      $display("[TB] FAIL prio_frozen got=%0d exp=52", d4);
    end
    bus_write(8'h30, 32'd1);
    bus_read(8'h38, d4, d8);
    n_cmp++;
    if (d4 !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL prio_restart got=%0d exp=0", d4);
    end
    bus_write(8'h08, 32'hF);
    bus_write(8'h44, 32'd0);
    bus_write(8'h40, 32'd3);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (timer !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL prio_pre_reset_timer got=%b exp=1", timer);
    end
    bus_write(8'h00, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (timer !== 1'b0 || ch_irq !== '0 || data_out !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL midreset_outputs got timer=%b irq=%h dout=%h exp 0/0/0",
               timer, ch_irq, data_out);
    end
    a_rd = '{8'h00, 8'h04, 8'h08, 8'h30, 8'h34, 8'h38, 8'h40};
    exp_rd = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    for (int k = 0; k < 7; k++) begin
      bus_read(a_rd[k], d4, d8);
      n_cmp++;
      if (d4 !== exp_rd[k]) begin
        n_err++;
        $display("[TB] FAIL midreset_read addr=%h got=%h exp=%h", a_rd[k], d4, exp_rd[k]);
      end
    end
  endtask

  task automatic test_wide();
    logic [31:0] d4, d8;
    logic [7:0] exp_seq [4];
    exp_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    do_reset();
    bus_write(8'h00, 32'd0);
    bus_write(8'h08, 32'h80);
    bus_write(8'h84, 32'hFF);
    bus_write(8'h80, 32'd3);
    bus_write(8'h88, 32'hFE);
    addr = 8'h88; rd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (data_out8 !== 32'(exp_seq[k])) begin
        n_err++;
        $display("[TB] FAIL wide_cnt step=%0d got=%h exp=%h", k, data_out8, exp_seq[k]);
      end
    end
    rd = 1'b0;
    n_cmp++;
    if (ch_irq8 !== 8'h80 || timer8 !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL wide_irq got irq=%h timer=%b exp 80/1", ch_irq8, timer8);
    end
    bus_read(8'h04, d4, d8);
    n_cmp++;
    if (d8 !== 32'h80) begin
      n_err++;
      $display("[TB] FAIL wide_pend got=%h exp=80", d8);
    end
    bus_read(8'h0C, d4, d8);
    n_cmp++;
    if (d4 !== 32'h0 || d8 !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL unmapped_0c got=%h/%h exp=0/0", d4, d8);
    end
  endtask

  task automatic test_random();
    logic [7:0] alist [18];
    logic [7:0] a;
    logic [31:0] d;
    bit w, r;
    alist = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20,
              8'h24, 8'h28, 8'h30, 8'h34, 8'h38, 8'h40, 8'h44, 8'h48, 8'h50};
    do_reset();
    model_reset();
    for (int k = 0; k < 600; k++) begin
      a = alist[$urandom_range(0, 17)];
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 1) == 1);
      case (int'(a) % 16)
        0: d = (a == 8'h00) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 3));
        4: d = (a == 8'h04) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 7));
        8: d = (a == 8'h08) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 9));
        default: d = $urandom;
      endcase
      addr = a; data_in = d; wr = w; rd = r;
      model_step(w, r, a, d);
      @(negedge clk);
      n_cmp++;
      if (data_out !== m_dout) begin
        n_err++;
        $display("[TB] FAIL rand_dout cyc=%0d got=%h exp=%h", cyc, data_out, m_dout);
      end
      n_cmp++;
      if (ch_irq !== m_irq) begin
        n_err++;
        $display("[TB] FAIL rand_irq cyc=%0d got=%h exp=%h", cyc, ch_irq, m_irq);
      end
      n_cmp++;
      if (timer !== m_timer) begin
        n_err++;
        $display("[TB] FAIL rand_timer cyc=%0d got=%b exp=%b", cyc, timer, m_timer);
      end
    end
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; data_in = '0;
    @(negedge clk);
    test_reset();
    test_periodic();
    test_oneshot();
    test_w1c_collision();
    test_priority();
    test_wide();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("[TB] FAIL watchdog cyc=%0d exp run to complete", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
